// File: rtl/cgra_column_seq_ctrl.sv
// Per-column program sequencer: owns the column PC, drives pc_en/conf_re into the RCs,
// resolves branch/stall/end requests from the rows and keeps saturating perf counters.
//
// state  | meaning
// IDLE   | waiting for a kernel launch, start_ready_o high
// LOAD   | one cycle, RCs latch the first instruction at pc_q
// RUN    | kernel executing, PC advances or branches unless stalled
// DONE   | one cycle, done_o pulse, then back to IDLE
module cgra_column_seq_ctrl #(
    parameter int N_ROW     = 4,
    parameter int PC_WIDTH  = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_valid_i,
    output logic                      start_ready_o,
    input  logic [PC_WIDTH-1:0]       start_pc_i,
    input  logic                      abort_i,
    input  logic [N_ROW-1:0]          rc_stall_i,
    input  logic [N_ROW-1:0]          br_req_i,
    input  logic [N_ROW*PC_WIDTH-1:0] br_add_i,
    input  logic [N_ROW-1:0]          exec_end_i,
    output logic [PC_WIDTH-1:0]       global_pc_o,
    output logic                      pc_en_o,
    output logic                      conf_re_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CNT_WIDTH-1:0]      cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

    logic                   stall;
    logic                   end_hit;
    logic                   br_any;
    logic [PC_WIDTH-1:0]    br_tgt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign stall   = |rc_stall_i;
    assign end_hit = (|exec_end_i) & ~stall;
    assign br_any  = |br_req_i;

    // Scan from the top row down so the lowest-indexed requester wins.
    always_comb begin
        br_tgt = '0;
        for (int r = N_ROW - 1; r >= 0; r--) begin
            if (br_req_i[r]) begin
                br_tgt = br_add_i[r*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid_i && !abort_i) begin
                    pc_d        = start_pc_i;
                    cycle_cnt_d = '0;
                    stall_cnt_d = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    pc_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    pc_d        = pc_q + PC_WIDTH'(1);
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    pc_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                    if (stall) begin
                        stall_cnt_d = sat_inc(stall_cnt_q);
                    end else if (end_hit) begin
                        state_d = S_DONE;
                    end else if (br_any) begin
                        pc_d = br_tgt;
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                end
            end
            default: begin
                if (abort_i) begin
                    pc_d = '0;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start_ready_o = 1'b0;
        pc_en_o       = 1'b0;
        conf_re_o     = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            S_IDLE: start_ready_o = 1'b1;
            S_LOAD: begin
                pc_en_o = 1'b1;
                busy_o  = 1'b1;
            end
            S_RUN: begin
                conf_re_o = 1'b1;
                busy_o    = 1'b1;
                pc_en_o   = ~stall & ~end_hit;
            end
            default: done_o = ~abort_i;
        endcase
    end

    assign global_pc_o = pc_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
